// File: rtl/bram_stream_reader.sv
// Read sequencer between a block RAM and a valid/ready stream: walks an address
// range on start, issues one-cycle-latency reads and buffers returns in a 4-deep FIFO.

module bram_stream_reader_chk (
    input logic i_clk,
    input logic i_rst_n,
    input logic i_push,
    input logic i_full,
    input logic i_read_en,
    input logic i_write_active
);
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_push && i_full));
    a_no_rw_clash: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_read_en && i_write_active));
endmodule

module bram_stream_reader #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DEPTH_BITS-1:0] base_addr,
    input  logic [DEPTH_BITS:0]   length,
    input  logic                  bram_write_active,
    output logic                  read_en,
    output logic [DEPTH_BITS-1:0] read_address,
    input  logic [WIDTH-1:0]      read_data_in,
    output logic [WIDTH-1:0]      m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_done_next;
    logic [DEPTH_BITS-1:0] r_base;
    logic [DEPTH_BITS:0]   r_length;
    logic [DEPTH_BITS:0]   r_issued;
    logic [DEPTH_BITS:0]   r_sent;
    logic [DEPTH_BITS:0]   w_issued_next;
    logic [DEPTH_BITS:0]   w_sent_next;
    logic                  r_pending;
    logic                  r_done;
    logic [WIDTH-1:0]      r_fifo [4];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_count;
    logic [3:0]            w_occupancy;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_accept;

    // Reads in flight count against FIFO space so returning data always fits.
    assign w_occupancy   = {1'b0, r_count} + {3'b000, r_pending};
    assign w_issue       = (r_state == S_RUN) && (r_issued < r_length) &&
                           !bram_write_active && (w_occupancy < 4'd4);
    assign w_push        = r_pending;
    assign w_pop         = m_tvalid && m_tready;
    assign w_full        = (r_count == 3'd4);
    assign w_issued_next = r_issued + {{DEPTH_BITS{1'b0}}, w_issue};
    assign w_sent_next   = r_sent + {{DEPTH_BITS{1'b0}}, w_pop};
    assign w_accept      = (r_state == S_IDLE) && (w_state_next != S_IDLE);

    assign read_en       = w_issue;
    assign read_address  = r_base + r_issued[DEPTH_BITS-1:0];
    assign m_tvalid      = (r_count != 3'd0);
    assign m_tdata       = r_fifo[r_rd_ptr];
    assign m_tlast       = m_tvalid && (r_sent == (r_length - {{DEPTH_BITS{1'b0}}, 1'b1}));
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;

    // Next-state logic; done is raised on the same step that returns to IDLE.
    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !r_done) begin
                    w_state_next = (length == '0) ? S_DRAIN : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_issued_next == r_length) begin
                    w_state_next = S_DRAIN;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_DRAIN: begin
                if (w_sent_next == r_length) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_state_next = S_DRAIN;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    // Transfer descriptor and progress counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base    <= '0;
            r_length  <= '0;
            r_issued  <= '0;
            r_sent    <= '0;
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_base    <= base_addr;
            r_length  <= length;
            r_issued  <= '0;
            r_sent    <= '0;
            r_pending <= 1'b0;
        end else begin
            r_issued  <= w_issued_next;
            r_sent    <= w_sent_next;
            r_pending <= w_issue;
        end
    end

    // Output FIFO: BRAM data lands here one cycle after its read enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= read_data_in;
                r_wr_ptr         <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    bram_stream_reader_chk u_chk (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_push         (w_push),
        .i_full         (w_full),
        .i_read_en      (read_en),
        .i_write_active (bram_write_active)
    );
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader (DEPTH_BITS = 4) with a BRAM model
// holding RAM[a] = a + 0x10.

module tb_bram_stream_reader;
    localparam int DB = 4;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DB-1:0] base_addr;
    logic [DB:0]   length;
    logic          bram_write_active;
    logic          read_en;
    logic [DB-1:0] read_address;
    logic [W-1:0]  read_data_in = 8'h00;
    logic [W-1:0]  m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          busy;
    logic          done;

    int    n_cmp = 0;
    int    n_bad = 0;
    string cur_tag = "";

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (read_en) read_data_in <= 8'h10 + {4'h0, read_address};
    end

    bram_stream_reader #(.WIDTH(W), .DEPTH_BITS(DB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .length(length), .bram_write_active(bram_write_active),
        .read_en(read_en), .read_address(read_address), .read_data_in(read_data_in),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .busy(busy), .done(done)
    );

    typedef struct {
        int base;
        int len;
        int stall;
        int wa_lo;
        int wa_hi;
        int sb;
        int exp_first;
        int exp_done;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %0d expected %0d", cur_tag, name, act, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v);
        int nrd = 0, npop = 0, first = -1, done_cyc = -1, last_hs = -1;
        int conflicts = 0, maxo = 0;
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [W-1:0] pd = '0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            start             = (k == 0) || (k == v.sb);
            base_addr         = (k == 0) ? DB'(v.base) : 4'd1;
            length            = (k == 0) ? 5'(v.len) : 5'd3;
            bram_write_active = (k >= v.wa_lo) && (k <= v.wa_hi);
            m_tready          = (v.stall == 0) ? 1'b1 : ($urandom_range(0, 99) >= v.stall);
            #1;
            if (k == 1) chk("busy_c1", 32'(busy), 32'd1);
            if (pv && !pr) begin
                chk("hold_valid", 32'(m_tvalid), 32'd1);
                chk("hold_data", 32'(m_tdata), 32'(pd));
                chk("hold_last", 32'(m_tlast), 32'(pl));
            end
            if (read_en) begin
                if (bram_write_active) conflicts++;
                chk("rd_addr", 32'(read_address), 32'((v.base + nrd) % 16));
                nrd++;
                if (nrd - npop > maxo) maxo = nrd - npop;
            end
            if (m_tvalid && first < 0) first = k;
            if (m_tvalid && m_tready) begin
                chk("beat_data", 32'(m_tdata), 32'(((v.base + npop) % 16) + 16));
                chk("beat_last", 32'(m_tlast), 32'(npop == v.len - 1));
                if (m_tlast) last_hs = k;
                npop++;
            end
            pv = m_tvalid;
            pr = m_tready;
            pd = m_tdata;
            pl = m_tlast;
            if (done) begin
                done_cyc = k;
                chk("busy_at_done", 32'(busy), 32'd0);
                break;
            end
        end
        start = 1'b0;
        bram_write_active = 1'b0;
        chk("done_seen", 32'(done_cyc >= 0), 32'd1);
        chk("beats", 32'(npop), 32'(v.len));
        chk("reads", 32'(nrd), 32'(v.len));
        chk("rw_conflicts", 32'(conflicts), 32'd0);
        chk("outstanding_le4", 32'(maxo <= 4), 32'd1);
        chk("first_valid", 32'(first), 32'(v.exp_first));
        if (v.exp_done >= 0) chk("done_cycle", 32'(done_cyc), 32'(v.exp_done));
        if (v.len > 0) chk("done_after_last", 32'(done_cyc - last_hs), 32'd1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_read_en", 32'(read_en), 32'd0);
        chk("rst_read_address", 32'(read_address), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
    endtask

    initial begin
        vec_t rv;
        int   npop;
        //            base len stall wa_lo wa_hi  sb first done
        vecs[0] = '{    5,  4,   0,   -1,   -1,  -1,   3,    7};
        vecs[1] = '{    0, 16,  30,   -1,   -1,  -1,   3,   -1};
        vecs[2] = '{    3,  8,   0,    2,    4,  -1,   3,   14};
        vecs[3] = '{   14,  4,   0,   -1,   -1,  -1,   3,    7};
        vecs[4] = '{    9, 16,   0,   -1,   -1,  -1,   3,   19};
        vecs[5] = '{    7,  0,   0,   -1,   -1,   1,  -1,    2};
        vecs[6] = '{    0,  6,   0,   -1,   -1,   3,   3,    9};

        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        bram_write_active = 1'b0;
        m_tready = 1'b1;
        cur_tag = "reset";
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            run_xfer(vecs[i]);
        end

        cur_tag = "midreset";
        npop = 0;
        @(negedge clk);
        start = 1'b1;
        base_addr = 4'd0;
        length = 5'd10;
        m_tready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (npop == 3) break;
            if (m_tvalid && m_tready) npop++;
        end
        chk("pops_before_reset", 32'(npop), 32'd3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("no_done_in_reset", 32'(done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("no_done_after_release", 32'(done), 32'd0);
        cur_tag = "post_reset";
        rv = '{4, 2, 0, -1, -1, -1, 3, 5};
        run_xfer(rv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
